spi_xfer_ctrl: RTL

Sequences multi-byte SPI transactions on top of the byte-level spi_master. Accepts one command holding a chip-select index and a byte count, then drives per-peripheral active-low chip selects with programmable setup, hold and idle gaps. Streams TX bytes from a valid/ready source into the master and forwards RX bytes to the requester. Sits between the system-side command logic and one spi_master instance.

---
 rtl/spi_ctrl_pkg.sv | 36 +++
 rtl/spi_gap_timer.sv | 34 +++
 rtl/spi_xfer_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_ctrl_pkg
// Shared state encoding, default timing and counter sizing for spi_xfer_ctrl.
// Rev    : 1.0
// ============================================================================
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  localparam int unsigned C_DEF_NUM_CS      = 2;
  localparam int unsigned C_DEF_LEN_W       = 8;
  localparam int unsigned C_DEF_SETUP_CLKS  = 4;
  localparam int unsigned C_DEF_HOLD_CLKS   = 4;
  localparam int unsigned C_DEF_IDLE_CLKS   = 8;

  // Counter only ever holds (N-1), so clog2 of the largest N is enough.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_gap_timer.sv
`default_nettype none
// ============================================================================
// Module : spi_gap_timer
// Load / count-down / expire timer shared by the SETUP, HOLD and GAP phases.
// Rev    : 1.0
// ============================================================================
module spi_gap_timer
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = cnt_width(C_DEF_SETUP_CLKS, C_DEF_HOLD_CLKS, C_DEF_IDLE_CLKS)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic             o_Expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (i_Load) begin
      r_cnt <= i_Load_Val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_Expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spi_xfer_ctrl
// Multi-byte SPI transaction sequencer with chip-select timing over spi_master.
// Rev    : 1.0
// ============================================================================
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CS        = C_DEF_NUM_CS,
  parameter int unsigned LEN_W         = C_DEF_LEN_W,
  parameter int unsigned CS_SETUP_CLKS = C_DEF_SETUP_CLKS,
  parameter int unsigned CS_HOLD_CLKS  = C_DEF_HOLD_CLKS,
  parameter int unsigned CS_IDLE_CLKS  = C_DEF_IDLE_CLKS
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Cmd_Valid,
  output logic              o_Cmd_Ready,
  input  logic [2:0]        i_Cmd_CS,
  input  logic [LEN_W-1:0]  i_Cmd_Len,
  input  logic              i_TX_Valid,
  input  logic [7:0]        i_TX_Byte,
  output logic              o_TX_Ready,
  output logic              o_RX_DV,
  output logic [7:0]        o_RX_Byte,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err,
  output logic [NUM_CS-1:0] o_SPI_CS_n,
  output logic [7:0]        o_Mst_TX_Byte,
  output logic              o_Mst_TX_DV,
  input  logic              i_Mst_TX_Ready,
  input  logic              i_Mst_RX_DV,
  input  logic [7:0]        i_Mst_RX_Byte
);

  localparam int unsigned       TW         = cnt_width(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
  localparam logic [TW-1:0]     C_SETUP_LD = TW'(CS_SETUP_CLKS - 1);
  localparam logic [TW-1:0]     C_HOLD_LD  = TW'(CS_HOLD_CLKS - 1);
  localparam logic [TW-1:0]     C_GAP_LD   = TW'(CS_IDLE_CLKS - 1);
  localparam logic [NUM_CS-1:0] C_CS_OFF   = '1;

  state_e            r_state, w_state_nx;
  logic [2:0]        r_cs_idx, w_cs_idx_nx;
  logic [LEN_W-1:0]  r_remaining, w_remaining_nx;
  logic              r_cmd_ready, w_cmd_ready_nx;
  logic              r_tx_ready, w_tx_ready_nx;
  logic              r_rx_dv, w_rx_dv_nx;
  logic [7:0]        r_rx_byte, w_rx_byte_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              r_err, w_err_nx;
  logic [NUM_CS-1:0] r_cs_n, w_cs_n_nx;
  logic [7:0]        r_mst_byte, w_mst_byte_nx;
  logic              r_mst_dv, w_mst_dv_nx;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_exp;
  logic              w_bad_cs;

  spi_gap_timer #(
    .WIDTH (TW)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (w_tmr_load),
    .i_Load_Val (w_tmr_val),
    .o_Expired  (w_tmr_exp)
  );

  assign w_bad_cs = ({1'b0, i_Cmd_CS} >= 4'(NUM_CS));

  always_comb begin
    w_state_nx     = r_state;
    w_cs_idx_nx    = r_cs_idx;
    w_remaining_nx = r_remaining;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    w_tx_ready_nx  = 1'b0;
    w_rx_dv_nx     = 1'b0;
    w_rx_byte_nx   = r_rx_byte;
    w_done_nx      = 1'b0;
    w_err_nx       = 1'b0;
    w_mst_byte_nx  = r_mst_byte;
    w_mst_dv_nx    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_Cmd_Valid && r_cmd_ready) begin
          if (w_bad_cs || (i_Cmd_Len == '0)) begin
            w_done_nx = 1'b1;
            w_err_nx  = w_bad_cs;
          end else begin
            w_state_nx     = ST_SETUP;
            w_cs_idx_nx    = i_Cmd_CS;
            w_remaining_nx = i_Cmd_Len;
            w_tmr_load     = 1'b1;
            w_tmr_val      = C_SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        if (w_tmr_exp) w_state_nx = ST_SEND;
      end
      ST_SEND: begin
        // Handshake decided here; ready/strobe land together next cycle while the source holds its byte.
        if (i_TX_Valid && i_Mst_TX_Ready) begin
          w_tx_ready_nx = 1'b1;
          w_mst_dv_nx   = 1'b1;
          w_mst_byte_nx = i_TX_Byte;
          w_state_nx    = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (i_Mst_RX_DV) begin
          w_rx_dv_nx   = 1'b1;
          w_rx_byte_nx = i_Mst_RX_Byte;
          if (r_remaining <= LEN_W'(1)) begin
            w_remaining_nx = '0;
            w_state_nx     = ST_HOLD;
            w_tmr_load     = 1'b1;
            w_tmr_val      = C_HOLD_LD;
          end else begin
            w_remaining_nx = r_remaining - 1'b1;
            w_state_nx     = ST_SEND;
          end
        end
      end
      ST_HOLD: begin
        if (w_tmr_exp) begin
          w_done_nx  = 1'b1;
          w_state_nx = ST_GAP;
          w_tmr_load = 1'b1;
          w_tmr_val  = C_GAP_LD;
        end
      end
      ST_GAP: begin
        if (w_tmr_exp) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    w_cmd_ready_nx = (w_state_nx == ST_IDLE);
    w_busy_nx      = (w_state_nx != ST_IDLE);
    w_cs_n_nx      = C_CS_OFF;
    if ((w_state_nx == ST_SETUP) || (w_state_nx == ST_SEND) ||
        (w_state_nx == ST_WAIT_RX) || (w_state_nx == ST_HOLD)) begin
      w_cs_n_nx = ~(NUM_CS'(1) << w_cs_idx_nx);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= ST_IDLE;
      r_cs_idx    <= '0;
      r_remaining <= '0;
      r_cmd_ready <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_dv     <= 1'b0;
      r_rx_byte   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cs_n      <= C_CS_OFF;
      r_mst_byte  <= '0;
      r_mst_dv    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cs_idx    <= w_cs_idx_nx;
      r_remaining <= w_remaining_nx;
      r_cmd_ready <= w_cmd_ready_nx;
      r_tx_ready  <= w_tx_ready_nx;
      r_rx_dv     <= w_rx_dv_nx;
      r_rx_byte   <= w_rx_byte_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_cs_n      <= w_cs_n_nx;
      r_mst_byte  <= w_mst_byte_nx;
      r_mst_dv    <= w_mst_dv_nx;
    end
  end

  assign o_Cmd_Ready   = r_cmd_ready;
  assign o_TX_Ready    = r_tx_ready;
  assign o_RX_DV       = r_rx_dv;
  assign o_RX_Byte     = r_rx_byte;
  assign o_Busy        = r_busy;
  assign o_Done        = r_done;
  assign o_Err         = r_err;
  assign o_SPI_CS_n    = r_cs_n;
  assign o_Mst_TX_Byte = r_mst_byte;
  assign o_Mst_TX_DV   = r_mst_dv;

endmodule
`default_nettype wire
